pipe_hazard_unit: RTL and testbench

//  Parametrised hazard and forwarding controller for the 5-stage ARMv8 pipeline; replaces the stand-alone forwarding block.

---
 rtl/pipe_hazard_unit.sv | 255 +++++++++++++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit
//
// Hazard and forwarding controller for the 5-stage ARMv8 pipeline
// (IF, ID, EX, MEM, WB). It is the single place that decides which
// pipeline registers advance, hold or are loaded with a bubble.
//
//   * Forwarding: for every source operand of the instruction in EX, pick
//     the EX/MEM result, the MEM/WB result or the register file.
//   * Load-use: when the instruction in ID reads the destination of a load
//     in EX, hold PC and IF/ID for one cycle and put a bubble into ID/EX.
//   * Taken branch: branches resolve in MEM; the three younger stages are
//     flushed and the PC takes the branch target.
//   * Data-memory wait: while MEM waits on data memory the whole pipeline
//     is frozen (front end held, back end held, nothing flushed).
//   * Wait timeout: a small FSM counts consecutive frozen cycles. Once the
//     limit is exceeded it enters ERR. That state is sticky until reset and
//     keeps the pipeline frozen.
//   * Debug: saturating counters for load-use bubbles, branch flushes and
//     freeze cycles. The FSM state is exported on the state port.
//
// Control priority: reset > ERR > freeze > branch > load-use > run.
// Register address 31 (XZR) never produces a forward or a hazard.
//
// Handshake note: dmem_req/dmem_ready form a valid/ready pair. A data-memory
// access completes in the cycle where dmem_req && dmem_ready are both high.
// A cycle with dmem_req high and dmem_ready low is a freeze cycle. MEM is
// held during a freeze, so its inputs (including mem_pcsrc) stay stable
// until the access completes.
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   synchronous, active-low
//   id_src        in   source register addresses of the ID instruction
//   id_src_vld    in   per-operand "operand actually read" flags for ID
//   ex_src        in   source register addresses of the EX instruction
//   ex_rd         in   destination of the EX instruction
//   ex_memread    in   EX instruction is a load
//   mem_rd        in   destination in EX/MEM
//   mem_regwrite  in   EX/MEM instruction writes a register
//   wb_rd         in   destination in MEM/WB
//   wb_regwrite   in   MEM/WB instruction writes a register
//   mem_pcsrc     in   branch in MEM is taken
//   dmem_req      in   MEM stage is accessing data memory
//   dmem_ready    in   data memory completes this cycle
//   pc_we         out  PC write enable
//   ifid_we       out  IF/ID write enable
//   ifid_flush    out  IF/ID loads a bubble
//   idex_flush    out  ID/EX loads a bubble
//   exmem_flush   out  EX/MEM loads a bubble
//   back_hold     out  hold EX/MEM and MEM/WB
//   fwd_sel       out  per EX operand: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   err           out  sticky data-memory timeout
//   stall_cnt     out  load-use bubble count (saturating)
//   flush_cnt     out  taken-branch flush count (saturating)
//   wait_cnt      out  freeze cycle count outside ERR (saturating)
//   state         out  FSM state: 0 RUN, 1 WAIT, 2 ERR
// ---------------------------------------------------------------------------
module pipe_hazard_unit #(
  parameter int RA_W     = 5,
  parameter int NUM_SRC  = 2,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SRC*RA_W-1:0]   id_src,
  input  logic [NUM_SRC-1:0]        id_src_vld,
  input  logic [NUM_SRC*RA_W-1:0]   ex_src,
  input  logic [RA_W-1:0]           ex_rd,
  input  logic                      ex_memread,
  input  logic [RA_W-1:0]           mem_rd,
  input  logic                      mem_regwrite,
  input  logic [RA_W-1:0]           wb_rd,
  input  logic                      wb_regwrite,
  input  logic                      mem_pcsrc,
  input  logic                      dmem_req,
  input  logic                      dmem_ready,
  output logic                      pc_we,
  output logic                      ifid_we,
  output logic                      ifid_flush,
  output logic                      idex_flush,
  output logic                      exmem_flush,
  output logic                      back_hold,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      err,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt,
  output logic [CNT_W-1:0]          wait_cnt,
  output logic [1:0]                state
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  localparam logic [RA_W-1:0]  XZR      = '1;
  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;

  logic in_err;
  logic freeze;
  logic branch;
  logic lu_hit;
  logic loaduse;

  // -------------------------------------------------------------------------
  // Event decode, with the priority folded in so that at most one of
  // freeze / branch / loaduse is active in any cycle outside ERR.
  // -------------------------------------------------------------------------
  assign in_err  = (state_q == ST_ERR);
  assign freeze  = dmem_req && !dmem_ready;
  assign branch  = mem_pcsrc && !freeze && !in_err;
  assign loaduse = ex_memread && lu_hit && !branch && !freeze && !in_err;

  // Any read operand of the ID instruction matching the load destination.
  // A load to XZR discards its result, so it never creates a dependency.
  always_comb begin
    lu_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_src_vld[i] && (id_src[i*RA_W +: RA_W] == ex_rd) && (ex_rd != XZR)) begin
        lu_hit = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Forwarding selects. EX/MEM holds the younger result, so it wins over
  // MEM/WB when both write the same register.
  // -------------------------------------------------------------------------
  always_comb begin
    fwd_sel = '0;
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (ex_src[i*RA_W +: RA_W] != XZR) begin
          if (mem_regwrite && (mem_rd == ex_src[i*RA_W +: RA_W])) begin
            fwd_sel[2*i +: 2] = 2'b10;
          end else if (wb_regwrite && (wb_rd == ex_src[i*RA_W +: RA_W])) begin
            fwd_sel[2*i +: 2] = 2'b01;
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pipeline control outputs.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    back_hold   = 1'b0;
    if (!reset) begin
      // Keep the front end still and fill every stage with bubbles so the
      // pipeline comes out of reset empty.
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (in_err || freeze) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      back_hold = 1'b1;
    end else if (branch) begin
      // PC takes the branch target; the three wrong-path instructions die.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (loaduse) begin
      // One bubble; the condition is re-evaluated in the next cycle.
      pc_we      = 1'b0;
      ifid_we    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Wait-timeout FSM. wcnt counts consecutive frozen cycles including the
  // one that left RUN, so the cycle after WAIT_MAX frozen cycles, if still
  // frozen, moves to ERR (WAIT_MAX + 1 frozen cycles in total).
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d = ST_WAIT;
          wcnt_d  = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (!freeze) begin
          state_d = ST_RUN;
          wcnt_d  = '0;
        end else if (wcnt_q >= WAIT_LIM) begin
          state_d = ST_ERR;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_RUN;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign err   = in_err;
  assign state = state_q;

  // -------------------------------------------------------------------------
  // Saturating event counters.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (loaduse && (stall_cnt != CNT_SAT)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (branch && (flush_cnt != CNT_SAT)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
      if (freeze && !in_err && (wait_cnt != CNT_SAT)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_unit
//
// Directed bench for pipe_hazard_unit with default parameters
// (RA_W=5, NUM_SRC=2, WAIT_MAX=15, CNT_W=16). Inputs are driven 1 time unit
// after the rising edge and outputs are checked 1 time unit later.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_unit;

  localparam int RA_W    = 5;
  localparam int NUM_SRC = 2;
  localparam int CNT_W   = 16;

  // ----- clock / reset -----
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [NUM_SRC*RA_W-1:0] id_src;
  logic [NUM_SRC-1:0]      id_src_vld;
  logic [NUM_SRC*RA_W-1:0] ex_src;
  logic [RA_W-1:0]         ex_rd;
  logic                    ex_memread;
  logic [RA_W-1:0]         mem_rd;
  logic                    mem_regwrite;
  logic [RA_W-1:0]         wb_rd;
  logic                    wb_regwrite;
  logic                    mem_pcsrc;
  logic                    dmem_req;
  logic                    dmem_ready;
  logic                    pc_we;
  logic                    ifid_we;
  logic                    ifid_flush;
  logic                    idex_flush;
  logic                    exmem_flush;
  logic                    back_hold;
  logic [NUM_SRC*2-1:0]    fwd_sel;
  logic                    err;
  logic [CNT_W-1:0]        stall_cnt;
  logic [CNT_W-1:0]        flush_cnt;
  logic [CNT_W-1:0]        wait_cnt;
  logic [1:0]              state;

  // {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, back_hold}
  logic [5:0] ctrl;
  assign ctrl = {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, back_hold};

  pipe_hazard_unit #(
    .RA_W(RA_W), .NUM_SRC(NUM_SRC), .WAIT_MAX(15), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .id_src(id_src), .id_src_vld(id_src_vld),
    .ex_src(ex_src), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .mem_pcsrc(mem_pcsrc), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .back_hold(back_hold),
    .fwd_sel(fwd_sel), .err(err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .wait_cnt(wait_cnt),
    .state(state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ----- driver tasks -----
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_idle();
    id_src       = '0;
    id_src_vld   = '0;
    ex_src       = '0;
    ex_rd        = '0;
    ex_memread   = 1'b0;
    mem_rd       = '0;
    mem_regwrite = 1'b0;
    wb_rd        = '0;
    wb_regwrite  = 1'b0;
    mem_pcsrc    = 1'b0;
    dmem_req     = 1'b0;
    dmem_ready   = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ----- reset: outputs forced even with matching forward inputs -----
    set_idle();
    reset        = 1'b0;
    mem_regwrite = 1'b1;
    mem_rd       = 5'd3;
    ex_src       = {5'd0, 5'd3};
    #2;
    chk("rst_ctrl", 32'(ctrl), 32'b001110);
    chk("rst_fwd", 32'(fwd_sel), 32'h0);
    tick();
    tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_cnts", {stall_cnt, flush_cnt} | 32'(wait_cnt), 32'h0);
    reset = 1'b1;
    set_idle();
    #1;
    chk("idle_ctrl", 32'(ctrl), 32'b110000);

    // ----- 1: forwarding -----
    mem_regwrite = 1'b1; mem_rd = 5'd3;
    wb_regwrite  = 1'b1; wb_rd  = 5'd3;
    ex_src       = {5'd0, 5'd3};
    #1;
    chk("fwd_exmem_wins", 32'(fwd_sel), 32'b0010);
    mem_regwrite = 1'b0;
    ex_src       = {5'd3, 5'd3};
    #1;
    chk("fwd_memwb_both", 32'(fwd_sel), 32'b0101);
    mem_regwrite = 1'b1; mem_rd = 5'd3; wb_rd = 5'd7;
    ex_src       = {5'd7, 5'd3};
    #1;
    chk("fwd_mixed", 32'(fwd_sel), 32'b0110);
    mem_rd = 5'd31; wb_rd = 5'd31;
    ex_src = {5'd31, 5'd31};
    #1;
    chk("fwd_xzr", 32'(fwd_sel), 32'b0000);
    set_idle();

    // ----- 2: load-use bubble -----
    tick();
    ex_memread = 1'b1; ex_rd = 5'd5;
    id_src     = {5'd5, 5'd0};
    id_src_vld = 2'b10;
    #1;
    chk("lu_ctrl", 32'(ctrl), 32'b000100);
    tick();
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    id_src_vld = 2'b01;
    #1;
    chk("lu_unread_op", 32'(ctrl), 32'b110000);
    ex_rd      = 5'd31;
    id_src     = {5'd31, 5'd0};
    id_src_vld = 2'b10;
    #1;
    chk("lu_xzr", 32'(ctrl), 32'b110000);
    tick();
    chk("lu_stall_hold", 32'(stall_cnt), 32'd1);
    set_idle();

    // ----- 3: branch beats load-use -----
    ex_memread = 1'b1; ex_rd = 5'd5;
    id_src     = {5'd5, 5'd0};
    id_src_vld = 2'b10;
    mem_pcsrc  = 1'b1;
    #1;
    chk("br_ctrl", 32'(ctrl), 32'b111110);
    tick();
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(stall_cnt), 32'd1);

    // ----- 4: four-cycle freeze, branch pending, then ready -----
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("frz_ctrl", 32'(ctrl), 32'b000001);
      tick();
    end
    chk("frz_state_wait", 32'(state), 32'd1);
    chk("frz_wait_cnt", 32'(wait_cnt), 32'd4);
    dmem_ready = 1'b1;
    #1;
    chk("frz_release_br", 32'(ctrl), 32'b111110);
    tick();
    chk("frz_state_run", 32'(state), 32'd0);
    chk("frz_flush_cnt", 32'(flush_cnt), 32'd2);
    chk("frz_stall_cnt", 32'(stall_cnt), 32'd1);
    set_idle();

    // ----- 5: timeout into sticky ERR, then reset -----
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    chk("to_err_15", 32'(err), 32'd0);
    chk("to_state_15", 32'(state), 32'd1);
    tick();
    chk("to_err_16", 32'(err), 32'd1);
    chk("to_state_err", 32'(state), 32'd2);
    chk("to_wait_cnt", 32'(wait_cnt), 32'd20);
    dmem_req  = 1'b0;
    mem_pcsrc = 1'b1;
    #1;
    chk("err_ctrl", 32'(ctrl), 32'b000001);
    tick();
    tick();
    chk("err_sticky", 32'(err), 32'd1);
    chk("err_wait_cnt", 32'(wait_cnt), 32'd20);
    chk("err_flush_cnt", 32'(flush_cnt), 32'd2);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_idle();
    #1;
    chk("err_rst_err", 32'(err), 32'd0);
    chk("err_rst_state", 32'(state), 32'd0);
    chk("err_rst_cnts", {stall_cnt, flush_cnt} | 32'(wait_cnt), 32'h0);

    // ----- 6: saturation -----
    tick();
    force dut.stall_cnt = 16'hFFFF;
    force dut.flush_cnt = 16'hFFFF;
    force dut.wait_cnt  = 16'hFFFF;
    #1;
    release dut.stall_cnt;
    release dut.flush_cnt;
    release dut.wait_cnt;
    ex_memread = 1'b1; ex_rd = 5'd9;
    id_src     = {5'd0, 5'd9};
    id_src_vld = 2'b01;
    tick();
    set_idle();
    mem_pcsrc = 1'b1;
    tick();
    set_idle();
    dmem_req = 1'b1;
    tick();
    set_idle();
    tick();
    chk("sat_stall", 32'(stall_cnt), 32'hFFFF);
    chk("sat_flush", 32'(flush_cnt), 32'hFFFF);
    chk("sat_wait", 32'(wait_cnt), 32'hFFFF);
    chk("sat_state_run", 32'(state), 32'd0);

    // ----- report -----
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
